// File: rtl/block_renderer_pkg.sv
// block_renderer_pkg: screen geometry, colour type, pixel payload and renderer
// state encoding shared by the x register, the renderer and the top level.
package block_renderer_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_MAX    = 144;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    typedef logic [COLOUR_W-1:0] colour_t;

    // One pixel write towards the VGA adapter.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        colour_t        colour;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ERASE,
        ST_DRAW,
        ST_PULSE
    } state_t;

endpackage

// File: rtl/block_renderer_if.sv
// block_renderer_if: pixel write bus from the renderer to the VGA adapter.
//   pix  - pixel coordinates and colour, valid whenever plot is high
//   plot - write enable
interface block_renderer_if;
    import block_renderer_pkg::*;

    pixel_t pix;
    logic   plot;

    modport master (output pix, output plot);
    modport slave  (input  pix, input  plot);

endinterface

// File: rtl/block_renderer_ticker.sv
// frame_ticker: free-running 0..FRAME_TICKS-1 counter; tick is high for the
// single cycle in which the count equals FRAME_TICKS-1.
//   clk, resetn - clock and async active-low reset
//   tick        - registered one-cycle frame strobe
module frame_ticker #(
    parameter int unsigned FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int unsigned      CNT_W = $clog2(FRAME_TICKS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // tick is registered off the next count so it lines up with cnt_q == LAST.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/block_renderer.sv
// block_renderer: once per frame erases the block at its previously drawn
// position, draws it at the current x, then pulses sync so the x register
// advances one pixel.
//   clk, resetn            - clock and async active-low reset
//   enable                 - frame ticks are ignored while low
//   curr_x, row_y, colour  - block position/colour, sampled in LATCH
//   bg_colour              - erase colour
//   sync                   - one-cycle pulse after each completed frame
//   busy                   - high in ERASE, DRAW and PULSE
//   overrun                - sticky: a frame tick arrived while not idle
//   vga                    - pixel write bus (master)
module block_renderer
    import block_renderer_pkg::*;
#(
    parameter int unsigned BLOCK_W     = 16,
    parameter int unsigned BLOCK_H     = 8,
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned SCREEN_W    = block_renderer_pkg::SCREEN_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [X_W-1:0]         curr_x,
    input  logic [Y_W-1:0]         row_y,
    input  colour_t                colour,
    input  colour_t                bg_colour,
    output logic                   sync,
    output logic                   busy,
    output logic                   overrun,
    block_renderer_if.master       vga
);

    localparam int unsigned      PIX_N    = BLOCK_W * BLOCK_H;
    localparam int unsigned      OFF_W    = $clog2(PIX_N);
    localparam int unsigned      DX_W     = $clog2(BLOCK_W);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PIX_N - 1);
    localparam logic [OFF_W-1:0] DX_MASK  = OFF_W'(BLOCK_W - 1);
    localparam logic [X_W:0]     X_LIMIT  = (X_W+1)'(SCREEN_W);

    logic tick;

    frame_ticker #(.FRAME_TICKS(FRAME_TICKS)) u_ticker (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    state_t           state_q, state_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [OFF_W-1:0] dx, dy;
    logic [X_W-1:0]   prev_x_q, new_x_q, new_x_d, base_x;
    logic [Y_W-1:0]   prev_y_q, new_y_q, new_y_d, base_y;
    colour_t          new_colour_q, new_colour_d;
    logic             drawn_valid_q;
    logic             commit;
    logic             walk_d;
    logic             plot_d;
    logic [X_W:0]     sum_x;
    pixel_t           pix_d;

    // Next state plus the pixel for the next cycle; outputs are registered
    // from the next-state view so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        commit       = 1'b0;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_colour_d = new_colour_q;

        case (state_q)
            ST_IDLE: begin
                if (tick && enable) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                new_x_d      = curr_x;
                new_y_d      = row_y;
                new_colour_d = colour;
                off_d        = '0;
                state_d      = drawn_valid_q ? ST_ERASE : ST_DRAW;
            end
            ST_ERASE: begin
                if (off_q == OFF_LAST) begin
                    off_d   = '0;
                    state_d = ST_DRAW;
                end else begin
                    off_d = off_q + OFF_W'(1);
                end
            end
            ST_DRAW: begin
                if (off_q == OFF_LAST) begin
                    off_d   = '0;
                    commit  = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    off_d = off_q + OFF_W'(1);
                end
            end
            ST_PULSE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Raster walk: dx is the low offset bits, so it runs fastest.
        walk_d       = (state_d == ST_ERASE) || (state_d == ST_DRAW);
        dx           = off_d & DX_MASK;
        dy           = off_d >> DX_W;
        base_x       = (state_d == ST_ERASE) ? prev_x_q : new_x_d;
        base_y       = (state_d == ST_ERASE) ? prev_y_q : new_y_d;
        sum_x        = {1'b0, base_x} + (X_W+1)'(dx);
        plot_d       = walk_d && (sum_x < X_LIMIT);
        pix_d.x      = sum_x[X_W-1:0];
        pix_d.y      = base_y + Y_W'(dy);
        pix_d.colour = (state_d == ST_ERASE) ? bg_colour : new_colour_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            off_q         <= '0;
            prev_x_q      <= '0;
            prev_y_q      <= '0;
            new_x_q       <= '0;
            new_y_q       <= '0;
            new_colour_q  <= '0;
            drawn_valid_q <= 1'b0;
            sync          <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            vga.plot      <= 1'b0;
            vga.pix       <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_colour_q <= new_colour_d;
            if (commit) begin
                prev_x_q      <= new_x_q;
                prev_y_q      <= new_y_q;
                drawn_valid_q <= 1'b1;
            end
            // Ticks landing outside IDLE are dropped but remembered.
            if (tick && (state_q != ST_IDLE)) overrun <= 1'b1;
            sync     <= (state_d == ST_PULSE);
            busy     <= walk_d || (state_d == ST_PULSE);
            vga.plot <= plot_d;
            if (walk_d) vga.pix <= pix_d;
        end
    end

endmodule

// File: doc/block_renderer.md
# block_renderer

Frame-paced drawing engine between the moving-block position logic and the VGA adapter. Once per frame it erases the block at its previously drawn position, draws it at the current x position, then issues a one-cycle `sync` pulse that lets the x register advance one pixel. It produces the `sync` strobe the x register consumes and reads back the resulting x position.

## Interface
- `BLOCK_W`, 16: block width in pixels, power of two.
- `BLOCK_H`, 8: block height in pixels, power of two.
- `FRAME_TICKS`, 833333: clk cycles per frame (60 Hz at 50 MHz); ≥ 2·BLOCK_W·BLOCK_H + 4.
- `SCREEN_W`, 160: visible width; pixels at x ≥ SCREEN_W are never plotted.
- `clk  in  1`: 50 MHz system clock.
- `resetn  in  1`: one clock; reset is asynchronous and active-low.
- `enable  in  1`: render and advance when high; frame ticks with enable low are ignored.
- `curr_x  in  8`: block left edge, from the x register.
- `row_y  in  7`: block top edge.
- `colour  in  3`: block colour.
- `bg_colour  in  3`: erase colour.
- `sync  out  1`: one-cycle pulse to the x register after each completed frame.
- `vga_x  out  8`, `vga_y  out  7`, `vga_colour  out  3`: pixel to write.
- `plot  out  1`: VGA write enable. The pixel fields are valid in any cycle `plot` is high.
- `busy  out  1`: high in ERASE, DRAW and PULSE.
- `overrun  out  1`: sticky flag, set when a frame tick lands while busy.

## Operation
- The frame counter is free-running, 0..FRAME_TICKS-1. `tick` is asserted when the count is FRAME_TICKS-1. The counter never stalls.
- FSM states: IDLE, LATCH, ERASE, DRAW, PULSE.
  - IDLE: on `tick` && `enable` → LATCH. Otherwise stay in IDLE.
  - LATCH (1 cycle): capture `curr_x`, `row_y`, `colour` into `new_*` registers. Clear the pixel offset. Go to ERASE if `drawn_valid`, else DRAW.
  - ERASE: walk offsets (dx, dy) in raster order (dx fastest) over BLOCK_W·BLOCK_H cycles.
    - Plot `prev_x+dx`, `prev_y+dy`, `bg_colour`.
    - After the last pixel, go to DRAW and clear the offset.
  - DRAW: same walk, plotting `new_x+dx`, `new_y+dy`, `new_colour`.
    - After the last pixel: copy `new_x`/`new_y` into `prev_x`/`prev_y`, set `drawn_valid`, go to PULSE.
  - PULSE (1 cycle): `sync`=1, then go to IDLE.
- `prev_*`, `new_*` and `colour` are held for the whole sequence. Changes to the inputs mid-frame have no effect until the next LATCH.
- Clipping: if `x+dx` (9-bit sum) ≥ SCREEN_W, `plot`=0 for that cycle, but the walk still advances. The y sum is 7-bit and wraps. Row placement is the caller's responsibility.
- `tick` in any state other than IDLE: set `overrun` and drop the tick. `overrun` clears only on reset.
- Dropping `enable` mid-sequence does not abort; the current frame completes, including `sync`.

## Timing
- Reset values:
  - state IDLE, counter 0, offset 0.
  - `sync`=0, `plot`=0, `busy`=0, `overrun`=0, `drawn_valid`=0.
  - `vga_x`/`vga_y`/`vga_colour`=0; `prev_*`/`new_*`=0.
- Reset asserted mid-sequence: all of the above take effect immediately and asynchronously. The partially drawn block is not erased.
- All outputs are registered.
- The first `plot` is 2 cycles after the `tick` cycle (tick → LATCH → first pixel register).
- Erase and draw each take exactly BLOCK_W·BLOCK_H consecutive `plot` cycles, with no gap between erase and draw.
- `sync` is high exactly 1 cycle, the cycle after the last DRAW pixel. `plot`=0 in that cycle.
- Sequence length: 1 + 2·W·H + 1 cycles (first frame 1 + W·H + 1).
- There is at most one `sync` per frame.

## Structure
- Shared package: screen constants (SCREEN_W=160, SCREEN_H=120, X_MAX=144) and the 3-bit colour type, common with the x register and the top level.
- One natural sub-module is `frame_ticker`: the parameterised free-running counter with a one-cycle `tick` output.
- The FSM, offset counters, `prev`/`new` registers and output registers stay in `block_renderer`.

## Test plan
All scenarios use FRAME_TICKS=300, BLOCK_W=4, BLOCK_H=2.

- **First frame.** Release reset, hold `enable`=1, `curr_x`=10, `row_y`=20, `colour`=3'b100. Expected:
  - No erase.
  - 8 plots: (10,20),(11,20),(12,20),(13,20),(10,21)…(13,21), colour 4.
  - `sync` on the cycle after the last plot, then 0.
- **Second frame.** Bench model increments `curr_x` to 11 on `sync`. Expected:
  - 8 erase plots at x 10–13 with `bg_colour`.
  - Then 8 draw plots at x 11–14.
  - Exactly one `sync`.
- **Enable low.** Hold `enable`=0 for 3 ticks. Expected: `plot` and `sync` stay 0 and `busy`=0. Raise `enable`: the next tick renders normally.
- **Clipping.** Set `curr_x`=158. Expected: only x=158 and x=159 plotted per row (4 plots total). The walk still takes 8 cycles and `sync` timing is unchanged.
- **Overrun.** Use FRAME_TICKS=10. Expected: `overrun` is set on the first tick during `busy`, stays set, and `sync` still appears once per completed sequence.
- **Reset mid-draw.** Pull `resetn` low during the 5th DRAW pixel. Expected:
  - `plot`, `sync` and `busy` go to 0 without waiting for a clock edge.
  - After release, the next frame draws with no erase.
